// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC next-address unit with a small return stack
// and run/halt control for the microprogrammed control unit.
module micro_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int COND_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    input  logic [2:0]                seq_op,
    input  logic [$clog2(COND_W)-1:0] cond_sel,
    input  logic [COND_W-1:0]         cond,
    input  logic [ADDR_W-1:0]         br_addr,
    input  logic [ADDR_W-1:0]         mbr_addr,
    output logic [ADDR_W-1:0]         mpc,
    output logic                      running,
    output logic                      halted,
    output logic                      stk_err
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [2:0] OP_INC   = 3'd0;
    localparam logic [2:0] OP_JMP   = 3'd1;
    localparam logic [2:0] OP_JMPC  = 3'd2;
    localparam logic [2:0] OP_JMPNC = 3'd3;
    localparam logic [2:0] OP_MBR   = 3'd4;
    localparam logic [2:0] OP_CALL  = 3'd5;
    localparam logic [2:0] OP_RET   = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] mpc_inc;
    logic              cond_bit;
    logic              full;
    logic              empty;
    logic              advance;
    logic              push;

    assign mpc_inc  = mpc + ADDR_W'(1);
    assign full     = (sp == SP_W'(STACK_DEPTH));
    assign empty    = (sp == '0);
    assign top_idx  = sp[IDX_W-1:0] - IDX_W'(1);
    assign cond_bit = (32'(cond_sel) < COND_W) ? cond[cond_sel] : 1'b0;
    assign advance  = (state == S_RUN) && !stall;
    assign push     = advance && (seq_op == OP_CALL) && !full;

    // Stack storage has no reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack[sp[IDX_W-1:0]] <= mpc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mpc     <= '0;
            state   <= S_IDLE;
            running <= 1'b0;
            halted  <= 1'b0;
            stk_err <= 1'b0;
            sp      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        halted  <= 1'b0;
                        mpc     <= mpc_inc;
                    end
                end
                S_RUN: begin
                    if (advance) begin
                        case (seq_op)
                            OP_INC:   mpc <= mpc_inc;
                            OP_JMP:   mpc <= br_addr;
                            OP_JMPC:  mpc <= cond_bit ? br_addr : mpc_inc;
                            OP_JMPNC: mpc <= cond_bit ? mpc_inc : br_addr;
                            OP_MBR:   mpc <= mbr_addr;
                            OP_CALL: begin
                                mpc <= br_addr;
                                if (full) begin
                                    stk_err <= 1'b1;
                                end else begin
                                    sp <= sp + SP_W'(1);
                                end
                            end
                            OP_RET: begin
                                if (empty) begin
                                    mpc     <= '0;
                                    stk_err <= 1'b1;
                                end else begin
                                    mpc <= stack[top_idx];
                                    sp  <= sp - SP_W'(1);
                                end
                            end
                            OP_HALT: begin
                                state   <= S_HALTED;
                                running <= 1'b0;
                                halted  <= 1'b1;
                            end
                            default: mpc <= mpc;
                        endcase
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vector table, call/return corner sequence,
// and random stimulus against a queue-based reference model.
module tb_micro_sequencer;
    logic       clk;
    logic       rst;
    logic       start;
    logic       stall;
    logic [2:0] seq_op;
    logic [2:0] cond_sel;
    logic [7:0] cond;
    logic [7:0] br_addr;
    logic [7:0] mbr_addr;
    logic [7:0] mpc;
    logic       running;
    logic       halted;
    logic       stk_err;

    int checks   = 0;
    int failures = 0;

    micro_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stall    (stall),
        .seq_op   (seq_op),
        .cond_sel (cond_sel),
        .cond     (cond),
        .br_addr  (br_addr),
        .mbr_addr (mbr_addr),
        .mpc      (mpc),
        .running  (running),
        .halted   (halted),
        .stk_err  (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stall;
        logic [2:0] op;
        logic [2:0] cs;
        logic [7:0] cond;
        logic [7:0] br;
        logic [7:0] mbr;
        logic [7:0] mpc;
        logic       run;
        logic       hlt;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    int m_state;
    int m_mpc;
    int m_err;
    int m_stk[$];

    task automatic add(input int r, input int st, input int sl,
                       input int op, input int cs, input int cd,
                       input int br, input int mb, input int e_mpc,
                       input int e_run, input int e_hlt, input int e_err);
        vec_t v;
        v.rst   = 1'(r);
        v.start = 1'(st);
        v.stall = 1'(sl);
        v.op    = 3'(op);
        v.cs    = 3'(cs);
        v.cond  = 8'(cd);
        v.br    = 8'(br);
        v.mbr   = 8'(mb);
        v.mpc   = 8'(e_mpc);
        v.run   = 1'(e_run);
        v.hlt   = 1'(e_hlt);
        v.err   = 1'(e_err);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input int br);
        rst     = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        seq_op  = 3'(op);
        br_addr = 8'(br);
        step();
    endtask

    task automatic model(input int r, input int st, input int sl,
                         input int op, input int cs, input int cd,
                         input int br, input int mb);
        int nxt;
        int c;
        if (r != 0) begin
            m_state = 0;
            m_mpc   = 0;
            m_err   = 0;
            m_stk.delete();
        end else if (m_state == 0) begin
            if (st != 0) m_state = 1;
        end else if (m_state == 2) begin
            if (st != 0) begin
                m_state = 1;
                m_mpc   = (m_mpc + 1) % 256;
            end
        end else if (sl == 0) begin
            nxt = (m_mpc + 1) % 256;
            c   = (cd >> cs) & 1;
            case (op)
                0: m_mpc = nxt;
                1: m_mpc = br;
                2: m_mpc = (c == 1) ? br : nxt;
                3: m_mpc = (c == 0) ? br : nxt;
                4: m_mpc = mb;
                5: begin
                    if (m_stk.size() == 4) m_err = 1;
                    else m_stk.push_back(nxt);
                    m_mpc = br;
                end
                6: begin
                    if (m_stk.size() == 0) begin
                        m_mpc = 0;
                        m_err = 1;
                    end else begin
                        m_mpc = m_stk.pop_back();
                    end
                end
                default: m_state = 2;
            endcase
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        seq_op   = 3'd0;
        cond_sel = 3'd0;
        cond     = 8'h00;
        br_addr  = 8'h00;
        mbr_addr = 8'h00;

        //   rst st sl op cs cond  br    mbr   mpc  run hlt err
        add(1, 0, 0, 0, 0, 0,    0,    0,    0,    0, 0, 0);
        add(0, 1, 0, 0, 0, 0,    0,    0,    0,    1, 0, 0);
        add(0, 0, 0, 0, 0, 0,    0,    0,    1,    1, 0, 0);
        add(0, 0, 0, 0, 0, 0,    0,    0,    2,    1, 0, 0);
        add(0, 0, 0, 0, 0, 0,    0,    0,    3,    1, 0, 0);
        add(0, 0, 0, 1, 0, 0,    5,    0,    5,    1, 0, 0);
        add(0, 0, 0, 2, 2, 'h04, 'h40, 0,    'h40, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0,    5,    0,    5,    1, 0, 0);
        add(0, 0, 0, 2, 2, 0,    'h40, 0,    6,    1, 0, 0);
        add(0, 0, 0, 3, 2, 0,    'h30, 0,    'h30, 1, 0, 0);
        add(0, 0, 0, 3, 2, 'h04, 'h10, 0,    'h31, 1, 0, 0);
        add(0, 0, 0, 4, 0, 0,    0,    41,   41,   1, 0, 0);
        add(0, 0, 0, 4, 0, 0,    'h77, 0,    0,    1, 0, 0);
        add(0, 0, 0, 1, 0, 0,    10,   0,    10,   1, 0, 0);
        add(0, 0, 0, 5, 0, 0,    'h80, 0,    'h80, 1, 0, 0);
        add(0, 0, 0, 6, 0, 0,    0,    0,    11,   1, 0, 0);
        add(0, 0, 0, 1, 0, 0,    'hFF, 0,    'hFF, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,    0,    0,    0,    1, 0, 0);
        add(0, 0, 1, 1, 0, 0,    7,    0,    0,    1, 0, 0);
        add(0, 0, 0, 1, 0, 0,    7,    0,    7,    1, 0, 0);
        add(0, 0, 0, 1, 0, 0,    20,   0,    20,   1, 0, 0);
        add(0, 0, 0, 7, 0, 0,    0,    0,    20,   0, 1, 0);
        add(0, 0, 0, 1, 0, 0,    99,   0,    20,   0, 1, 0);
        add(0, 1, 0, 1, 0, 0,    99,   0,    21,   1, 0, 0);
        add(0, 0, 0, 0, 0, 0,    0,    0,    22,   1, 0, 0);
        add(1, 1, 1, 1, 0, 0,    99,   0,    0,    0, 0, 0);
        add(0, 0, 0, 1, 0, 0,    99,   0,    0,    0, 0, 0);

        foreach (tbl[i]) begin
            rst      = tbl[i].rst;
            start    = tbl[i].start;
            stall    = tbl[i].stall;
            seq_op   = tbl[i].op;
            cond_sel = tbl[i].cs;
            cond     = tbl[i].cond;
            br_addr  = tbl[i].br;
            mbr_addr = tbl[i].mbr;
            step();
            check($sformatf("vec%0d_mpc", i), int'(mpc), int'(tbl[i].mpc));
            check($sformatf("vec%0d_running", i), int'(running), int'(tbl[i].run));
            check($sformatf("vec%0d_halted", i), int'(halted), int'(tbl[i].hlt));
            check($sformatf("vec%0d_stk_err", i), int'(stk_err), int'(tbl[i].err));
        end

        // nested calls: overflow on the 5th, LIFO unwind, underflow on the 5th RET
        rst   = 1'b0;
        start = 1'b1;
        step();
        check("call_start_running", int'(running), 1);
        for (int k = 1; k <= 4; k++) begin
            drive(5, k * 16);
            check($sformatf("call%0d_mpc", k), int'(mpc), k * 16);
            check($sformatf("call%0d_err", k), int'(stk_err), 0);
        end
        drive(5, 'h50);
        check("call5_mpc", int'(mpc), 'h50);
        check("call5_err", int'(stk_err), 1);
        for (int k = 3; k >= 0; k--) begin
            drive(6, 0);
            check($sformatf("ret_lvl%0d_mpc", k), int'(mpc), k * 16 + 1);
        end
        drive(6, 'h33);
        check("ret_empty_mpc", int'(mpc), 0);
        check("ret_empty_err", int'(stk_err), 1);
        drive(0, 0);
        check("err_sticky_mpc", int'(mpc), 1);
        check("err_sticky", int'(stk_err), 1);

        // random stimulus against the reference model
        for (int i = 0; i < 3000; i++) begin
            int r, st, sl, op, cs, cd, br, mb;
            r  = (i == 0 || $urandom_range(99) == 0) ? 1 : 0;
            st = ($urandom_range(2) == 0) ? 1 : 0;
            sl = ($urandom_range(3) == 0) ? 1 : 0;
            op = int'($urandom_range(7));
            cs = int'($urandom_range(7));
            cd = int'($urandom_range(255));
            br = int'($urandom_range(255));
            mb = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255));
            rst      = 1'(r);
            start    = 1'(st);
            stall    = 1'(sl);
            seq_op   = 3'(op);
            cond_sel = 3'(cs);
            cond     = 8'(cd);
            br_addr  = 8'(br);
            mbr_addr = 8'(mb);
            model(r, st, sl, op, cs, cd, br, mb);
            step();
            check("rnd_mpc", int'(mpc), m_mpc);
            check("rnd_running", int'(running), (m_state == 1) ? 1 : 0);
            check("rnd_halted", int'(halted), (m_state == 2) ? 1 : 0);
            check("rnd_stk_err", int'(stk_err), m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
